svi_responder: RTL and testbench

//  Slave (responder) end of the svi interface. Connects to the svi.slave modport, opposite the
//  svi.master initiators in the subsystem. Services single read/write requests against a local

---
 rtl/svi_responder_if.sv | 15 +
 rtl/svi_responder.sv | 72 +++++++
 tb/tb_svi_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/svi_responder_if.sv
// svi: single-request bus between an initiator (master) and a register responder (slave)
interface svi #(
   parameter int AW = 8,
   parameter int DW = 32
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic          err;
   logic [DW-1:0] rdata;
   modport master (output req, we, addr, wdata, input ack, err, rdata);
   modport slave (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/svi_responder.sv
// svi_responder: svi slave endpoint serving a local register array with wait states,
// out-of-range error responses and a wrapping completed-transaction counter
module svi_responder #(
   parameter int AW    = 8,
   parameter int DW    = 32,
   parameter int DEPTH = 16,
   parameter int WAIT  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   svi.slave           svi_slave,
   output logic        busy,
   output logic [15:0] txn_cnt
);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;
   state_t        state;
   logic [3:0]    cnt;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] mem [DEPTH];
   logic          go;
   logic          ok;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   // with WAIT=0 the response is issued on the capture edge, so use the live request there
   always_comb begin
      c_we    = state == S_IDLE ? svi_slave.we : we;
      c_addr  = state == S_IDLE ? svi_slave.addr : addr;
      c_wdata = state == S_IDLE ? svi_slave.wdata : wdata;
      ok      = {1'b0, c_addr} < (AW + 1)'(DEPTH);
      go      = (state == S_IDLE && svi_slave.req && WAIT == 0) || (state == S_WAIT && cnt == 4'd1);
   end
   assign busy = state == S_WAIT || state == S_RESP;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         cnt             <= '0;
         we              <= 1'b0;
         addr            <= '0;
         wdata           <= '0;
         svi_slave.ack   <= 1'b0;
         svi_slave.err   <= 1'b0;
         svi_slave.rdata <= '0;
         txn_cnt         <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         svi_slave.ack   <= go;
         svi_slave.err   <= go && !ok;
         svi_slave.rdata <= (go && ok && !c_we) ? mem[c_addr[IW-1:0]] : '0;
         if (go) txn_cnt <= txn_cnt + 16'd1;
         if (go && ok && c_we) mem[c_addr[IW-1:0]] <= c_wdata;
         case (state)
            S_IDLE: if (svi_slave.req) begin
               we    <= svi_slave.we;
               addr  <= svi_slave.addr;
               wdata <= svi_slave.wdata;
               cnt   <= 4'(WAIT);
               state <= WAIT == 0 ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_RESP;
            end
            S_RESP: state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_svi_responder.sv
// tb_svi_responder: three responders (WAIT=1,0,15) driven with directed and random
// transactions, checked against an array-based model of the register file and counter
module tb_svi_responder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req = '0;
   logic [2:0]  we = '0;
   logic [2:0]  ack;
   logic [2:0]  err;
   logic [2:0]  busy;
   logic [7:0]  addr [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic [15:0] cnt [3];
   logic [31:0] mem_m [3][16];
   logic [15:0] cnt_m [3];
   int          wt [3] = '{1, 0, 15};
   int          total = 0;
   int          bad = 0;
   svi #(.AW(8), .DW(32)) b0 ();
   svi #(.AW(8), .DW(32)) b1 ();
   svi #(.AW(8), .DW(32)) b2 ();
   assign b0.req = req[0];
   assign b0.we = we[0];
   assign b0.addr = addr[0];
   assign b0.wdata = wdata[0];
   assign b1.req = req[1];
   assign b1.we = we[1];
   assign b1.addr = addr[1];
   assign b1.wdata = wdata[1];
   assign b2.req = req[2];
   assign b2.we = we[2];
   assign b2.addr = addr[2];
   assign b2.wdata = wdata[2];
   assign ack = {b2.ack, b1.ack, b0.ack};
   assign err = {b2.err, b1.err, b0.err};
   assign rdata[0] = b0.rdata;
   assign rdata[1] = b1.rdata;
   assign rdata[2] = b2.rdata;
   svi_responder #(.AW(8), .DW(32), .DEPTH(16), .WAIT(1)) u0 (.clk(clk), .rst_n(rst_n), .svi_slave(b0), .busy(busy[0]), .txn_cnt(cnt[0]));
   svi_responder #(.AW(8), .DW(32), .DEPTH(16), .WAIT(0)) u1 (.clk(clk), .rst_n(rst_n), .svi_slave(b1), .busy(busy[1]), .txn_cnt(cnt[1]));
   svi_responder #(.AW(8), .DW(32), .DEPTH(16), .WAIT(15)) u2 (.clk(clk), .rst_n(rst_n), .svi_slave(b2), .busy(busy[2]), .txn_cnt(cnt[2]));
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         cnt_m[s] = '0;
         for (int i = 0; i < 16; i++) mem_m[s][i] = '0;
      end
   endtask

   // one transaction on responder s, started at a negedge with the responder idle;
   // drop>0 releases req after that many cycles, a2!=a swaps addr/wdata mid-wait
   task automatic txn(input int s, input logic w, input logic [7:0] a, input logic [31:0] d,
                      input int drop, input logic [7:0] a2);
      int k;
      logic ok;
      logic [31:0] rd_exp;
      ok = a < 8'd16;
      rd_exp = (ok && !w) ? mem_m[s][a[3:0]] : 32'd0;
      req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
      k = 0;
      do begin
         @(posedge clk); @(negedge clk); k++;
         if (k == drop) req[s] = 1'b0;
         if (k == 4 && a2 != a) begin addr[s] = a2; wdata[s] = ~d; end
      end while (!ack[s] && k < 40);
      req[s] = 1'b0;
      if (ok && w) mem_m[s][a[3:0]] = d;
      cnt_m[s] = cnt_m[s] + 16'd1;
      total++; if (k !== wt[s] + 1) begin bad++; $display("FAIL latency s=%0d a=%0d got=%0d exp=%0d", s, a, k, wt[s] + 1); end
      total++; if (err[s] !== !ok) begin bad++; $display("FAIL err s=%0d a=%0d got=%b exp=%b", s, a, err[s], !ok); end
      total++; if (rdata[s] !== rd_exp) begin bad++; $display("FAIL rdata s=%0d a=%0d got=%h exp=%h", s, a, rdata[s], rd_exp); end
      @(negedge clk);
      total++; if ({ack[s], err[s], busy[s], rdata[s]} !== 35'd0) begin
         bad++; $display("FAIL turnaround s=%0d ack=%b err=%b busy=%b rdata=%h exp all 0", s, ack[s], err[s], busy[s], rdata[s]);
      end
      total++; if (cnt[s] !== cnt_m[s]) begin bad++; $display("FAIL txn_cnt s=%0d got=%h exp=%h", s, cnt[s], cnt_m[s]); end
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         total++; if ({ack[s], err[s], busy[s], rdata[s], cnt[s]} !== 51'd0) begin
            bad++; $display("FAIL reset_state s=%0d ack=%b err=%b busy=%b rdata=%h cnt=%h exp all 0", s, ack[s], err[s], busy[s], rdata[s], cnt[s]);
         end
      end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      txn(2, 1'b1, 8'd3, 32'h1111_1111, 0, 8'd3);
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'd3; wdata[2] = 32'h2222_2222;
      repeat (5) @(negedge clk);
      total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL busy_in_wait got=%b exp=1", busy[2]); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({ack[2], err[2], busy[2], rdata[2], cnt[2]} !== 51'd0) begin
         bad++; $display("FAIL async_reset ack=%b err=%b busy=%b rdata=%h cnt=%h exp all 0", ack[2], err[2], busy[2], rdata[2], cnt[2]);
      end
      req[2] = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn(2, 1'b0, 8'd3, 32'd0, 0, 8'd3);
   endtask

   task automatic test_write_read();
      txn(0, 1'b1, 8'd3, 32'hDEAD_BEEF, 0, 8'd3);
      txn(0, 1'b0, 8'd3, 32'd0, 0, 8'd3);
      total++; if (cnt[0] !== 16'd2) begin bad++; $display("FAIL wr_rd_count got=%0d exp=2", cnt[0]); end
   endtask

   task automatic test_range();
      txn(0, 1'b0, 8'd16, 32'd0, 0, 8'd16);
      txn(0, 1'b1, 8'd20, 32'hCAFE_F00D, 0, 8'd20);
      txn(0, 1'b1, 8'd255, 32'h1234_5678, 0, 8'd255);
      for (int i = 0; i < 16; i++) txn(0, 1'b0, 8'(i), 32'd0, 0, 8'(i));
   endtask

   task automatic test_back_to_back();
      int n;
      int last;
      txn(1, 1'b1, 8'd7, $urandom, 0, 8'd7);
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'd7; wdata[1] = '0;
      n = 0; last = 0;
      for (int t = 1; t <= 40 && n < 4; t++) begin
         @(posedge clk); @(negedge clk);
         if (ack[1]) begin
            n++;
            if (n == 4) req[1] = 1'b0;
            cnt_m[1] = cnt_m[1] + 16'd1;
            total++; if (rdata[1] !== mem_m[1][7]) begin bad++; $display("FAIL b2b_rdata n=%0d got=%h exp=%h", n, rdata[1], mem_m[1][7]); end
            if (n > 1) begin
               total++; if (t - last !== 3) begin bad++; $display("FAIL b2b_spacing n=%0d got=%0d exp=3", n, t - last); end
            end
            last = t;
         end
      end
      req[1] = 1'b0;
      total++; if (n !== 4) begin bad++; $display("FAIL b2b_acks got=%0d exp=4", n); end
      @(negedge clk); @(negedge clk);
      total++; if (cnt[1] !== cnt_m[1]) begin bad++; $display("FAIL b2b_count got=%h exp=%h", cnt[1], cnt_m[1]); end
      txn(2, 1'b0, 8'd9, 32'd0, 0, 8'd9);
   endtask

   task automatic test_addr_change();
      txn(2, 1'b1, 8'd5, 32'h5555_5555, 0, 8'd5);
      txn(2, 1'b1, 8'd3, 32'hA5A5_0303, 0, 8'd5);
      txn(2, 1'b0, 8'd3, 32'd0, 0, 8'd3);
      txn(2, 1'b0, 8'd5, 32'd0, 0, 8'd5);
   endtask

   task automatic test_req_drop();
      txn(2, 1'b1, 8'd11, 32'h0BAD_CAFE, 1, 8'd11);
      txn(0, 1'b1, 8'd12, 32'h1357_9BDF, 1, 8'd12);
      txn(2, 1'b0, 8'd11, 32'd0, 0, 8'd11);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++)
         txn($urandom_range(0, 1), 1'($urandom), 8'($urandom_range(0, 19)), $urandom, 0, 8'd0);
   endtask

   task automatic test_wrap();
      force u1.txn_cnt = 16'hFFFF;
      @(posedge clk);
      #1 release u1.txn_cnt;
      cnt_m[1] = 16'hFFFF;
      @(negedge clk);
      total++; if (cnt[1] !== 16'hFFFF) begin bad++; $display("FAIL preload got=%h exp=ffff", cnt[1]); end
      txn(1, 1'b0, 8'd2, 32'd0, 0, 8'd2);
      total++; if (cnt[1] !== 16'h0000) begin bad++; $display("FAIL wrap got=%h exp=0000", cnt[1]); end
   endtask

   initial begin
      for (int s = 0; s < 3; s++) begin addr[s] = '0; wdata[s] = '0; end
      test_reset();
      test_write_read();
      test_range();
      test_back_to_back();
      test_addr_change();
      test_req_drop();
      test_random();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
